mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the decode/execute operand latch.
- Consumes the latched memOp/memSize/rd/aluToReg fields plus the ALU result (address) and store data.
- Runs load/store transactions on the data bus via a req/ack handshake and back-pressures the latch through memStall.
- Produces registered writeback (data, rd, enable) and a misalignment/bus-fault report.

Parameters:
TIMEOUT_CYCLES, 255, cycles dReq may stay unacknowledged before a bus fault is raised; must be 1..65535.

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
aluResult  input  32  ALU output; effective address for memory ops, writeback data otherwise
storeData  input  32  rs2 value for stores
memOp  input  2  00 none, 01 load, 10 store, 11 treated as none
memSize  input  2  00 byte, 01 half, 10 word, 11 illegal
memUnsigned  input  1  1 = zero-extend loads (LBU/LHU)
rd  input  5  destination register
aluToReg  input  1  non-memory op writes rd
memStall  output  1  combinational; holds the upstream latch
dReq  output  1  bus request
dWe  output  1  1 store, 0 load
dAddr  output  32  word-aligned address (low 2 bits 0)
dWdata  output  32  lane-replicated store data
dByteEn  output  4  byte enables
dAck  input  1  request accepted/completed this cycle (may be same cycle as dReq)
dErr  input  1  valid with dAck; bus error
dRdata  input  32  read data, valid with dAck
wbData  output  32  writeback data
wbRd  output  5  writeback register
wbEn  output  1  writeback enable
memFault  output  1  one-cycle fault pulse
faultAddr  output  32  faulting effective address
faultIsStore  output  1  fault came from a store

Behaviour:
- Reset (synchronous): state IDLE, timeout counter 0.
  - All registered outputs are 0: wbData, wbRd, wbEn, dReq, dWe, dAddr, dWdata, dByteEn, memFault, faultAddr, faultIsStore.
  - Reset mid-transaction abandons it: dReq=0 next cycle, no writeback, no fault.
- States:
  - IDLE: no bus request outstanding.
  - BUSY: dReq=1, waiting for dAck.
- Classification, from current inputs:
  - isMem = memOp is 01 or 10.
  - misaligned = memSize 11, or half with aluResult[0]=1, or word with aluResult[1:0]≠0.
- memStall = (IDLE & isMem & ~misaligned) | (BUSY & ~dAck & ~timeout).
  - Upstream holds inputs stable while memStall=1.
- IDLE, non-mem op:
  - Next cycle: wbData=aluResult, wbRd=rd, wbEn=aluToReg.
  - Latency 1, no stall.
- IDLE, isMem & misaligned:
  - No bus access, no stall.
  - Next cycle: memFault=1, faultAddr=aluResult, faultIsStore=(memOp==10), wbEn=0.
- IDLE, isMem & aligned:
  - Register dReq=1, dWe, dAddr={aluResult[31:2],2'b00}, dByteEn, dWdata; capture lane, size, unsigned flag and rd.
  - Go to BUSY; counter cleared.
- BUSY:
  - dReq and all request fields held constant until dAck.
  - Counter increments each cycle without dAck.
- BUSY & dAck & ~dErr:
  - dReq=0 next cycle; go to IDLE.
  - Load: wbData=extracted value, wbRd=captured rd, wbEn=1.
  - Store: wbEn=0.
- BUSY & dAck & dErr: same as above but wbEn=0, memFault pulse, faultAddr=full effective address.
- BUSY & counter reaches TIMEOUT_CYCLES-1 without dAck:
  - Fault exactly as dErr; dReq dropped; go to IDLE.
  - A dAck arriving later is ignored.
- Minimum load latency:
  - Cycle 0 op presented with stall=1.
  - Cycle 1 dReq with same-cycle dAck, stall=0.
  - Cycle 2 wbEn=1.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load extract:
  - Select the byte/half at the lane.
  - Sign-extend from bit 7/15 unless memUnsigned.
  - Word loads ignore memUnsigned.
- wbEn and memFault are never both 1.
- wbEn is 0 during any cycle not immediately following a completion or non-mem op.

Decomposition:
- Package mem_pkg:
  - MEMOP_NONE/LOAD/STORE constants.
  - SIZE_B/H/W constants.
  - State encoding IDLE/BUSY.
  - Default TIMEOUT.
- One combinational sub-module, mem_align:
  - Inputs: addr[1:0], size, unsigned, storeData, rdata.
  - Outputs: byteEn, wdata, loadData, misaligned.

Test Plan:
- ALU op, aluResult=0x1234, rd=5, aluToReg=1 → next cycle wbData=0x1234, wbRd=5, wbEn=1, memStall never 1.
- Store byte, addr=0x1003, data=0xAB → dReq=1, dWe=1, dAddr=0x1000, dByteEn=1000, dWdata=0xABABABAB; dAck after 3 cycles → wbEn=0, memStall drops in the ack cycle.
- Load half signed, addr=0x2002, dRdata=0x8001_7FFF, same-cycle ack → wbData=0xFFFF8001; with memUnsigned=1 → 0x00008001.
- Load word, addr=0x3001 → no dReq; next cycle memFault=1, faultAddr=0x3001, faultIsStore=0, wbEn=0.
- TIMEOUT_CYCLES=4, load, dAck never asserted → fault after 4 BUSY cycles, dReq=0, memStall=0; a late dAck produces no writeback.
- reset asserted while BUSY → next cycle dReq=0, wbEn=0, memFault=0, state IDLE; a following word load at 0x40 completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared encodings for the memory-access stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : data-bus request/ack channel between the stage and memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dByteEn;
    logic        dAck;
    logic        dErr;
    logic [31:0] dRdata;

    modport master (
        output dReq, dWe, dAddr, dWdata, dByteEn,
        input  dAck, dErr, dRdata
    );

    modport slave (
        input  dReq, dWe, dAddr, dWdata, dByteEn,
        output dAck, dErr, dRdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// mem_align : byte-lane steering, store replication and load extraction
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_align
    import mem_pkg::*;
(
    input  wire logic [1:0]  i_addr,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    input  wire logic [31:0] i_storeData,
    input  wire logic [31:0] i_rdata,
    output logic      [3:0]  o_byteEn,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_loadData,
    output logic             o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_byteEn   = 4'b0000;
        o_wdata    = i_storeData;
        o_loadData = i_rdata;
        case (i_size)
            SIZE_B: begin
                o_byteEn   = 4'b0001 << i_addr;
                o_wdata    = {4{i_storeData[7:0]}};
                o_loadData = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_H: begin
                o_byteEn   = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata    = {2{i_storeData[15:0]}};
                o_loadData = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SIZE_W: begin
                o_byteEn   = 4'b1111;
                o_wdata    = i_storeData;
                o_loadData = i_rdata;
            end
            default: begin
                o_byteEn   = 4'b0000;
                o_wdata    = i_storeData;
                o_loadData = i_rdata;
            end
        endcase
    end

    assign o_misaligned = (i_size == SIZE_ILL)
                        | ((i_size == SIZE_H) & i_addr[0])
                        | ((i_size == SIZE_W) & (i_addr != 2'b00));

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : load/store bus sequencer with registered writeback and faults
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] aluResult,
    input  wire logic [31:0] storeData,
    input  wire logic [1:0]  memOp,
    input  wire logic [1:0]  memSize,
    input  wire logic        memUnsigned,
    input  wire logic [4:0]  rd,
    input  wire logic        aluToReg,
    output logic             memStall,
    mem_stage_if.master      bus,
    output logic      [31:0] wbData,
    output logic      [4:0]  wbRd,
    output logic             wbEn,
    output logic             memFault,
    output logic      [31:0] faultAddr,
    output logic             faultIsStore
);

    localparam logic [15:0] c_TMAX = 16'(TIMEOUT_CYCLES - 1);

    mem_state_t  r_state;
    logic [15:0] r_cnt;
    logic        r_dReq;
    logic        r_dWe;
    logic [31:0] r_dAddr;
    logic [31:0] r_dWdata;
    logic [3:0]  r_dByteEn;
    logic [31:0] r_effAddr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic [31:0] r_wbData;
    logic [4:0]  r_wbRd;
    logic        r_wbEn;
    logic        r_memFault;
    logic [31:0] r_faultAddr;
    logic        r_faultIsStore;

    logic        w_busy;
    logic        w_isMem;
    logic        w_isStore;
    logic        w_timeout;
    logic [1:0]  w_alAddr;
    logic [1:0]  w_alSize;
    logic        w_alUnsigned;
    logic [3:0]  w_byteEn;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;
    logic        w_misaligned;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_isMem   = is_mem_op(memOp);
    assign w_isStore = (memOp == MEMOP_STORE);
    assign w_timeout = w_busy & (r_cnt == c_TMAX);

    // While BUSY the aligner must extract using the captured access, not live inputs.
    assign w_alAddr     = w_busy ? r_effAddr[1:0] : aluResult[1:0];
    assign w_alSize     = w_busy ? r_size         : memSize;
    assign w_alUnsigned = w_busy ? r_unsigned     : memUnsigned;

    mem_align u_align (
        .i_addr       (w_alAddr),
        .i_size       (w_alSize),
        .i_unsigned   (w_alUnsigned),
        .i_storeData  (storeData),
        .i_rdata      (bus.dRdata),
        .o_byteEn     (w_byteEn),
        .o_wdata      (w_wdata),
        .o_loadData   (w_loadData),
        .o_misaligned (w_misaligned)
    );

    assign memStall = (~w_busy & w_isMem & ~w_misaligned)
                    | (w_busy & ~bus.dAck & ~w_timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_dReq         <= 1'b0;
            r_dWe          <= 1'b0;
            r_dAddr        <= 32'd0;
            r_dWdata       <= 32'd0;
            r_dByteEn      <= 4'd0;
            r_effAddr      <= 32'd0;
            r_size         <= 2'd0;
            r_unsigned     <= 1'b0;
            r_rd           <= 5'd0;
            r_wbData       <= 32'd0;
            r_wbRd         <= 5'd0;
            r_wbEn         <= 1'b0;
            r_memFault     <= 1'b0;
            r_faultAddr    <= 32'd0;
            r_faultIsStore <= 1'b0;
        end else begin
            r_wbEn     <= 1'b0;
            r_memFault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_isMem) begin
                        r_wbData <= aluResult;
                        r_wbRd   <= rd;
                        r_wbEn   <= aluToReg;
                    end else if (w_misaligned) begin
                        r_memFault     <= 1'b1;
                        r_faultAddr    <= aluResult;
                        r_faultIsStore <= w_isStore;
                    end else begin
                        r_dReq     <= 1'b1;
                        r_dWe      <= w_isStore;
                        r_dAddr    <= {aluResult[31:2], 2'b00};
                        r_dByteEn  <= w_byteEn;
                        r_dWdata   <= w_wdata;
                        r_effAddr  <= aluResult;
                        r_size     <= memSize;
                        r_unsigned <= memUnsigned;
                        r_rd       <= rd;
                        r_cnt      <= 16'd0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.dAck) begin
                        r_dReq  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (bus.dErr) begin
                            r_memFault     <= 1'b1;
                            r_faultAddr    <= r_effAddr;
                            r_faultIsStore <= r_dWe;
                        end else if (!r_dWe) begin
                            r_wbData <= w_loadData;
                            r_wbRd   <= r_rd;
                            r_wbEn   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_dReq         <= 1'b0;
                        r_state        <= ST_IDLE;
                        r_memFault     <= 1'b1;
                        r_faultAddr    <= r_effAddr;
                        r_faultIsStore <= r_dWe;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dReq     = r_dReq;
    assign bus.dWe      = r_dWe;
    assign bus.dAddr    = r_dAddr;
    assign bus.dWdata   = r_dWdata;
    assign bus.dByteEn  = r_dByteEn;

    assign wbData       = r_wbData;
    assign wbRd         = r_wbRd;
    assign wbEn         = r_wbEn;
    assign memFault     = r_memFault;
    assign faultAddr    = r_faultAddr;
    assign faultIsStore = r_faultIsStore;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed checks of mem_stage with a 4-cycle bus timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic        memUnsigned;
    logic [4:0]  rd;
    logic        aluToReg;
    logic        memStall;
    logic [31:0] wbData;
    logic [4:0]  wbRd;
    logic        wbEn;
    logic        memFault;
    logic [31:0] faultAddr;
    logic        faultIsStore;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .aluResult    (aluResult),
        .storeData    (storeData),
        .memOp        (memOp),
        .memSize      (memSize),
        .memUnsigned  (memUnsigned),
        .rd           (rd),
        .aluToReg     (aluToReg),
        .memStall     (memStall),
        .bus          (bus_if),
        .wbData       (wbData),
        .wbRd         (wbRd),
        .wbEn         (wbEn),
        .memFault     (memFault),
        .faultAddr    (faultAddr),
        .faultIsStore (faultIsStore)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memOp       = MEMOP_NONE;
        aluToReg    = 1'b0;
        memUnsigned = 1'b0;
        bus_if.dAck = 1'b0;
        bus_if.dErr = 1'b0;
    endtask

    task automatic present(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r);
        memOp       = op;
        memSize     = sz;
        memUnsigned = uns;
        aluResult   = addr;
        storeData   = sd;
        rd          = r;
        aluToReg    = 1'b0;
        #1;
    endtask

    // One-cycle same-edge-ack load; checks the writeback that follows.
    task automatic load_fast(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [4:0] r, input logic [31:0] exp);
        present(MEMOP_LOAD, sz, uns, addr, 32'h0, r);
        step();
        bus_if.dAck   = 1'b1;
        bus_if.dRdata = rdata;
        #1;
        check({tag, "_stall_ack"}, memStall, 0);
        step();
        idle_inputs();
        check({tag, "_wbData"}, wbData, exp);
        check({tag, "_wbRd"}, wbRd, r);
        check({tag, "_wbEn"}, wbEn, 1);
    endtask

    initial begin
        reset         = 1'b1;
        aluResult     = 32'h0;
        storeData     = 32'h0;
        memSize       = SIZE_B;
        rd            = 5'd0;
        bus_if.dRdata = 32'h0;
        idle_inputs();
        step();
        step();
        check("rst_wbEn", wbEn, 0);
        check("rst_wbData", wbData, 0);
        check("rst_dReq", bus_if.dReq, 0);
        check("rst_dAddr", bus_if.dAddr, 0);
        check("rst_memFault", memFault, 0);
        check("rst_faultAddr", faultAddr, 0);
        reset = 1'b0;

        // Plain ALU writeback
        aluResult = 32'h1234; rd = 5'd5; aluToReg = 1'b1; memOp = MEMOP_NONE;
        #1;
        check("alu_stall", memStall, 0);
        step();
        idle_inputs();
        check("alu_wbData", wbData, 32'h1234);
        check("alu_wbRd", wbRd, 5);
        check("alu_wbEn", wbEn, 1);

        // Store byte, ack on the third BUSY cycle
        present(MEMOP_STORE, SIZE_B, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0);
        check("stb_stall_idle", memStall, 1);
        step();
        check("stb_dReq", bus_if.dReq, 1);
        check("stb_dWe", bus_if.dWe, 1);
        check("stb_dAddr", bus_if.dAddr, 32'h1000);
        check("stb_dByteEn", bus_if.dByteEn, 4'b1000);
        check("stb_dWdata", bus_if.dWdata, 32'hABABABAB);
        check("stb_stall_busy", memStall, 1);
        step();
        step();
        check("stb_dReq_held", bus_if.dReq, 1);
        check("stb_dAddr_held", bus_if.dAddr, 32'h1000);
        bus_if.dAck = 1'b1;
        #1;
        check("stb_stall_ack", memStall, 0);
        step();
        idle_inputs();
        check("stb_dReq_done", bus_if.dReq, 0);
        check("stb_wbEn", wbEn, 0);
        check("stb_fault", memFault, 0);

        // Half/byte loads with sign/zero extension
        load_fast("lhs", SIZE_H, 1'b0, 32'h2002, 32'h8001_7FFF, 5'd7, 32'hFFFF8001);
        load_fast("lhu", SIZE_H, 1'b1, 32'h2002, 32'h8001_7FFF, 5'd8, 32'h0000_8001);
        load_fast("lbs", SIZE_B, 1'b0, 32'h2001, 32'h1234_8056, 5'd9, 32'hFFFF_FF80);
        load_fast("lhl", SIZE_H, 1'b0, 32'h2000, 32'h8001_7FFF, 5'd10, 32'h0000_7FFF);

        // Misaligned word load
        present(MEMOP_LOAD, SIZE_W, 1'b0, 32'h3001, 32'h0, 5'd4);
        check("mis_stall", memStall, 0);
        step();
        idle_inputs();
        check("mis_dReq", bus_if.dReq, 0);
        check("mis_fault", memFault, 1);
        check("mis_faultAddr", faultAddr, 32'h3001);
        check("mis_isStore", faultIsStore, 0);
        check("mis_wbEn", wbEn, 0);
        step();
        check("mis_fault_pulse", memFault, 0);

        // Misaligned half store
        present(MEMOP_STORE, SIZE_H, 1'b0, 32'h3003, 32'h55, 5'd0);
        step();
        idle_inputs();
        check("mish_fault", memFault, 1);
        check("mish_isStore", faultIsStore, 1);

        // Bus error on a word store
        present(MEMOP_STORE, SIZE_W, 1'b0, 32'h600, 32'hCAFE_F00D, 5'd0);
        step();
        check("stw_dByteEn", bus_if.dByteEn, 4'b1111);
        check("stw_dWdata", bus_if.dWdata, 32'hCAFE_F00D);
        bus_if.dAck = 1'b1;
        bus_if.dErr = 1'b1;
        step();
        idle_inputs();
        check("err_fault", memFault, 1);
        check("err_faultAddr", faultAddr, 32'h600);
        check("err_isStore", faultIsStore, 1);
        check("err_wbEn", wbEn, 0);
        check("err_dReq", bus_if.dReq, 0);

        // Timeout: four BUSY cycles without ack
        present(MEMOP_LOAD, SIZE_W, 1'b0, 32'h500, 32'h0, 5'd9);
        step();
        check("to_stall_c1", memStall, 1);
        step();
        step();
        check("to_stall_c3", memStall, 1);
        step();
        check("to_stall_c4", memStall, 0);
        check("to_dReq_c4", bus_if.dReq, 1);
        step();
        idle_inputs();
        check("to_dReq", bus_if.dReq, 0);
        check("to_fault", memFault, 1);
        check("to_faultAddr", faultAddr, 32'h500);
        check("to_isStore", faultIsStore, 0);
        check("to_wbEn", wbEn, 0);
        bus_if.dAck   = 1'b1;
        bus_if.dRdata = 32'h1111_2222;
        #1;
        check("to_stall_after", memStall, 0);
        step();
        bus_if.dAck = 1'b0;
        check("to_late_wbEn", wbEn, 0);
        check("to_late_fault", memFault, 0);

        // Reset while BUSY, then a clean word load
        present(MEMOP_LOAD, SIZE_W, 1'b0, 32'h40, 32'h0, 5'd3);
        step();
        check("rb_dReq", bus_if.dReq, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rb_dReq_rst", bus_if.dReq, 0);
        check("rb_wbEn_rst", wbEn, 0);
        check("rb_fault_rst", memFault, 0);
        check("rb_stall_idle", memStall, 1);
        step();
        check("rb_dReq2", bus_if.dReq, 1);
        check("rb_dAddr2", bus_if.dAddr, 32'h40);
        bus_if.dAck   = 1'b1;
        bus_if.dRdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        check("rb_wbData", wbData, 32'hDEAD_BEEF);
        check("rb_wbRd", wbRd, 3);
        check("rb_wbEn", wbEn, 1);
        check("rb_fault", memFault, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
